// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its fetch and data requesters, and the shared memory.
// The arbiter takes the slave modport; the surrounding environment takes the master modport.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        me_req;
  logic        me_we;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [31:0] me_rdata;
  logic        me_ack;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        timeout_err;

  modport slave (
    input  if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, me_rdata, me_ack, mem_valid, mem_we, mem_addr, mem_wdata,
           stall, timeout_err
  );

  modport master (
    output if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, me_rdata, me_ack, mem_valid, mem_we, mem_addr, mem_wdata,
           stall, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port with a wait-state timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to the data port.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_ME, ACK} state_t;

  localparam logic [8:0]  TO_LIMIT     = 9'(TIMEOUT_CYCLES);
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] me_rdata_q, me_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        me_ack_q, me_ack_d;
  logic        terr_q, terr_d;

  logic        any_req;
  logic        grant_me;
  logic        busy;
  logic        timed_out;
  logic        done;
  logic [31:0] result;

  assign any_req = bus.if_req | bus.me_req;
  assign busy    = (state_q == BUSY_IF) || (state_q == BUSY_ME);
  // cnt_q holds the stalled cycles already spent, so this cycle is stalled cycle cnt_q+1.
  assign timed_out = busy && !bus.mem_ready && (TO_LIMIT != 9'd0) &&
                     (({1'b0, cnt_q} + 9'd1) == TO_LIMIT);
  assign done   = busy && (bus.mem_ready || timed_out);
  assign result = bus.mem_ready ? bus.mem_rdata : TIMEOUT_WORD;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_me_q, last_me_d;

  // On a tie the side not served last wins; ME counts as last out of reset so IF wins first.
  assign grant_me = bus.me_req && (!bus.if_req || !last_me_q);

  always_comb begin
    last_me_d = last_me_q;
    if ((state_q == IDLE) && any_req) last_me_d = grant_me;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_me_q <= 1'b1;
    else        last_me_q <= last_me_d;
  end
`else
  assign grant_me = bus.me_req;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = grant_me ? BUSY_ME : BUSY_IF;
      BUSY_IF: if (done) state_d = ACK;
      BUSY_ME: if (done) state_d = ACK;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    me_rdata_d  = me_rdata_q;
    if_ack_d    = 1'b0;
    me_ack_d    = 1'b0;
    terr_d      = terr_q | timed_out;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          cnt_d       = 8'd0;
          mem_addr_d  = grant_me ? bus.me_addr : bus.if_addr;
          mem_we_d    = grant_me & bus.me_we;
          mem_wdata_d = grant_me ? bus.me_wdata : 32'h0;
        end
      end
      BUSY_IF: begin
        if (!bus.mem_ready) cnt_d = cnt_q + 8'd1;
        if (done) begin
          if_ack_d   = 1'b1;
          if_rdata_d = result;
        end
      end
      BUSY_ME: begin
        if (!bus.mem_ready) cnt_d = cnt_q + 8'd1;
        if (done) begin
          me_ack_d = 1'b1;
          if (!mem_we_q) me_rdata_d = result;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      me_rdata_q  <= 32'h0;
      if_ack_q    <= 1'b0;
      me_ack_q    <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
      if_ack_q    <= if_ack_d;
      me_ack_q    <= me_ack_d;
      terr_q      <= terr_d;
    end
  end

  // mem_valid follows the state directly so it drops the instant reset asserts.
  assign bus.mem_valid   = busy;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.me_rdata    = me_rdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.me_ack      = me_ack_q;
  assign bus.timeout_err = terr_q;
  assign bus.stall       = (bus.if_req & ~if_ack_q) | (bus.me_req & ~me_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized, self-checking bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int          TO   = 4;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state and per-transaction expectations.
  logic        m_last_me;
  logic [31:0] m_if_rdata, m_me_rdata;
  logic        m_terr;
  logic        e_me, e_to, e_we;
  int          e_valid_n;
  logic [31:0] e_addr, e_wdata;

  // Observations gathered by the driver.
  int          o_valid_n;
  logic        o_stable, o_stall_busy, o_stall_ack, o_valid_ack, o_if_ack, o_me_ack, o_terr, o_ack_after;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_if_rdata, o_me_rdata;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_if_rdata = 32'h0;
    m_me_rdata = 32'h0;
    m_terr     = 1'b0;
    m_last_me  = 1'b1;
  endtask

  task automatic model_txn(input logic rq_if, input logic rq_me, input logic we,
                           input logic [31:0] aif, input logic [31:0] ame, input logic [31:0] wd,
                           input int wait_n, input logic [31:0] word);
    logic [31:0] res;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    e_me = (rq_if && rq_me) ? !m_last_me : rq_me;
`else
    e_me = rq_me;
`endif
    e_to      = (TO != 0) && (wait_n >= TO);
    e_valid_n = e_to ? TO : wait_n + 1;
    e_addr    = e_me ? ame : aif;
    e_we      = e_me && we;
    e_wdata   = e_me ? wd : 32'h0;
    res       = e_to ? DEAD : word;
    if (!e_me) m_if_rdata = res;
    else if (!we) m_me_rdata = res;
    m_terr    = m_terr | e_to;
    m_last_me = e_me;
  endtask

  task automatic idle_bus();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.me_req = 1'b0; bus.me_we = 1'b0; bus.me_addr = 32'h0; bus.me_wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_bus();
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Runs one transaction from an IDLE cycle; returns in the IDLE cycle after the ack.
  task automatic drive_txn(input logic rq_if, input logic rq_me, input logic we,
                           input logic [31:0] aif, input logic [31:0] ame, input logic [31:0] wd,
                           input int wait_n, input logic [31:0] word);
    bus.if_req = rq_if; bus.if_addr = aif;
    bus.me_req = rq_me; bus.me_we = we; bus.me_addr = ame; bus.me_wdata = wd;
    tick();
    o_valid_n = 0; o_stable = 1'b1; o_stall_busy = 1'b0;
    o_addr = 32'h0; o_wdata = 32'h0; o_we = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bus.mem_valid !== 1'b1) break;
      if (k == 0) begin
        o_addr = bus.mem_addr; o_we = bus.mem_we; o_wdata = bus.mem_wdata; o_stall_busy = bus.stall;
      end else if (bus.mem_addr !== o_addr || bus.mem_we !== o_we || bus.mem_wdata !== o_wdata) begin
        o_stable = 1'b0;
      end
      o_valid_n++;
      bus.mem_ready = (k == wait_n);
      bus.mem_rdata = (k == wait_n) ? word : $urandom;
      tick();
      bus.mem_ready = 1'b0;
      if (k == wait_n) break;
    end
    o_valid_ack = bus.mem_valid; o_if_ack = bus.if_ack; o_me_ack = bus.me_ack;
    o_stall_ack = bus.stall; o_terr = bus.timeout_err;
    o_if_rdata = bus.if_rdata; o_me_rdata = bus.me_rdata;
    bus.if_req = 1'b0; bus.me_req = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
    tick();
    bus.mem_ready = 1'b0;
    o_ack_after = bus.if_ack | bus.me_ack | bus.mem_valid;
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1'b0;
    @(posedge clock);
    #3;
    total++; if (bus.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%0b want=0", bus.mem_valid); end
    total++; if ({bus.if_ack, bus.me_ack} !== 2'b00) begin bad++; $display("FAIL rst_acks got=%b want=00", {bus.if_ack, bus.me_ack}); end
    total++; if (bus.if_rdata !== 32'h0 || bus.me_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", bus.if_rdata, bus.me_rdata); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%0b want=0", bus.timeout_err); end
    total++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_fields got=%h/%h/%0b want=0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", bus.stall); end
    #6;
    reset = 1'b1;
    model_reset();
    // mem_ready pulses while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
      tick();
      total++; if (bus.mem_valid !== 1'b0 || bus.if_ack !== 1'b0 || bus.me_ack !== 1'b0) begin bad++; $display("FAIL idle_ready_ignored got=%0b%0b%0b want=000", bus.mem_valid, bus.if_ack, bus.me_ack); end
      total++; if (bus.if_rdata !== m_if_rdata || bus.me_rdata !== m_me_rdata) begin bad++; $display("FAIL idle_rdata got=%h/%h want=%h/%h", bus.if_rdata, bus.me_rdata, m_if_rdata, m_me_rdata); end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_single_fetch();
    logic [31:0] junk_a, junk_d;
    junk_a = $urandom; junk_d = $urandom;
    model_txn(1'b1, 1'b0, 1'b1, 32'h40, junk_a, junk_d, 1, 32'h20080005);
    drive_txn(1'b1, 1'b0, 1'b1, 32'h40, junk_a, junk_d, 1, 32'h20080005);
    total++; if (o_if_ack !== 1'b1 || o_me_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack got=if%0b/me%0b want=if1/me0", o_if_ack, o_me_ack); end
    total++; if (o_valid_n != e_valid_n) begin bad++; $display("FAIL fetch_valid_cycles got=%0d want=%0d", o_valid_n, e_valid_n); end
    total++; if (o_addr !== e_addr || o_we !== e_we || o_wdata !== e_wdata) begin bad++; $display("FAIL fetch_fields got=%h/%0b/%h want=%h/%0b/%h", o_addr, o_we, o_wdata, e_addr, e_we, e_wdata); end
    total++; if (o_if_rdata !== m_if_rdata) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", o_if_rdata, m_if_rdata); end
    total++; if (o_stall_busy !== 1'b1 || o_stall_ack !== 1'b0) begin bad++; $display("FAIL fetch_stall got=busy%0b/ack%0b want=busy1/ack0", o_stall_busy, o_stall_ack); end
    total++; if (o_valid_ack !== 1'b0 || o_ack_after !== 1'b0) begin bad++; $display("FAIL fetch_ack_window got=valid%0b/after%0b want=0/0", o_valid_ack, o_ack_after); end
  endtask

  task automatic test_write_wait();
    model_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 0, 32'h13572468);
    drive_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 0, 32'h13572468);
    total++; if (o_me_ack !== 1'b1 || o_me_rdata !== m_me_rdata) begin bad++; $display("FAIL read_me got=ack%0b/%h want=ack1/%h", o_me_ack, o_me_rdata, m_me_rdata); end
    // Ready on the last stalled cycle before the limit: a normal completion.
    model_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hCAFEF00D, 3, 32'h0BADF00D);
    drive_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hCAFEF00D, 3, 32'h0BADF00D);
    total++; if (o_valid_n != 4 || o_stable !== 1'b1) begin bad++; $display("FAIL write_valid got=%0d stable=%0b want=4 stable=1", o_valid_n, o_stable); end
    total++; if (o_addr !== 32'h100 || o_we !== 1'b1 || o_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL write_fields got=%h/%0b/%h want=00000100/1/cafef00d", o_addr, o_we, o_wdata); end
    total++; if (o_me_ack !== 1'b1 || o_if_ack !== 1'b0) begin bad++; $display("FAIL write_ack got=me%0b/if%0b want=me1/if0", o_me_ack, o_if_ack); end
    total++; if (o_me_rdata !== m_me_rdata) begin bad++; $display("FAIL write_rdata_kept got=%h want=%h", o_me_rdata, m_me_rdata); end
    total++; if (o_terr !== 1'b0) begin bad++; $display("FAIL write_no_err got=%0b want=0", o_terr); end
  endtask

  task automatic test_tie();
    logic exp_me [3];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_me[0] = 1'b0; exp_me[1] = 1'b1; exp_me[2] = 1'b0;
`else
    exp_me[0] = 1'b1; exp_me[1] = 1'b1; exp_me[2] = 1'b1;
`endif
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w;
      w = $urandom;
      model_txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 32'h0, 0, w);
      drive_txn(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 32'h0, 0, w);
      total++; if (o_me_ack !== exp_me[i] || o_if_ack !== !exp_me[i]) begin bad++; $display("FAIL tie_grant%0d got=me%0b/if%0b want=me%0b", i, o_me_ack, o_if_ack, exp_me[i]); end
      total++; if (o_addr !== e_addr) begin bad++; $display("FAIL tie_addr%0d got=%h want=%h", i, o_addr, e_addr); end
      total++; if (o_stall_ack !== 1'b1) begin bad++; $display("FAIL tie_loser_stall%0d got=%0b want=1", i, o_stall_ack); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    model_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1000, 32'h0);
    drive_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1000, 32'h0);
    total++; if (o_valid_n != TO || o_valid_ack !== 1'b0) begin bad++; $display("FAIL to_valid got=%0d/%0b want=%0d/0", o_valid_n, o_valid_ack, TO); end
    total++; if (o_if_ack !== 1'b1 || o_if_rdata !== DEAD) begin bad++; $display("FAIL to_ack got=%0b/%h want=1/deadbeef", o_if_ack, o_if_rdata); end
    total++; if (o_terr !== 1'b1) begin bad++; $display("FAIL to_err got=%0b want=1", o_terr); end
    w = $urandom;
    model_txn(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h0, 2, w);
    drive_txn(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h0, 2, w);
    total++; if (o_if_rdata !== m_if_rdata || o_terr !== 1'b1) begin bad++; $display("FAIL to_after_good got=%h/%0b want=%h/1", o_if_rdata, o_terr, m_if_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    total++; if (bus.timeout_err !== m_terr) begin bad++; $display("FAIL mid_pre_err got=%0b want=%0b", bus.timeout_err, m_terr); end
    bus.me_req = 1'b1; bus.me_we = 1'b0; bus.me_addr = 32'h500;
    tick();
    tick();
    tick();
    total++; if (bus.mem_valid !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b want=1", bus.mem_valid); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (bus.mem_valid !== 1'b0 || bus.me_ack !== 1'b0) begin bad++; $display("FAIL mid_async got=valid%0b/ack%0b want=0/0", bus.mem_valid, bus.me_ack); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL mid_err_clr got=%0b want=0", bus.timeout_err); end
    idle_bus();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    tick();
    total++; if (bus.mem_valid !== 1'b0 || bus.me_ack !== 1'b0 || bus.if_ack !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0b%0b%0b want=000", bus.mem_valid, bus.me_ack, bus.if_ack); end
    w = $urandom;
    model_txn(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 0, w);
    drive_txn(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 0, w);
    total++; if (o_if_ack !== 1'b1 || o_if_rdata !== m_if_rdata || o_addr !== 32'h600) begin bad++; $display("FAIL mid_next got=%0b/%h/%h want=1/%h/00000600", o_if_ack, o_if_rdata, o_addr, m_if_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r;
      logic        we;
      logic [31:0] aif, ame, wd, w;
      int          wn;
      r = 2'($urandom_range(1, 3));
      we = 1'($urandom); aif = $urandom; ame = $urandom; wd = $urandom; w = $urandom;
      wn = $urandom_range(0, 6);
      model_txn(r[0], r[1], we, aif, ame, wd, wn, w);
      drive_txn(r[0], r[1], we, aif, ame, wd, wn, w);
      total++; if (o_me_ack !== e_me || o_if_ack !== !e_me) begin bad++; $display("FAIL rnd%0d_grant got=me%0b/if%0b want=me%0b", i, o_me_ack, o_if_ack, e_me); end
      total++; if (o_valid_n != e_valid_n || o_stable !== 1'b1) begin bad++; $display("FAIL rnd%0d_valid got=%0d/%0b want=%0d/1", i, o_valid_n, o_stable, e_valid_n); end
      total++; if (o_addr !== e_addr || o_we !== e_we || o_wdata !== e_wdata) begin bad++; $display("FAIL rnd%0d_fields got=%h/%0b/%h want=%h/%0b/%h", i, o_addr, o_we, o_wdata, e_addr, e_we, e_wdata); end
      total++; if (o_if_rdata !== m_if_rdata || o_me_rdata !== m_me_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h/%h want=%h/%h", i, o_if_rdata, o_me_rdata, m_if_rdata, m_me_rdata); end
      total++; if (o_terr !== m_terr) begin bad++; $display("FAIL rnd%0d_err got=%0b want=%0b", i, o_terr, m_terr); end
      total++; if (o_ack_after !== 1'b0 || bus.if_rdata !== m_if_rdata || bus.me_rdata !== m_me_rdata) begin bad++; $display("FAIL rnd%0d_after got=%0b/%h/%h want=0/%h/%h", i, o_ack_after, bus.if_rdata, bus.me_rdata, m_if_rdata, m_me_rdata); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_fetch();
    test_write_wait();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 0..255: maximum wait cycles for mem_ready before abort; 0 disables the timeout.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports if_req (in, 1) fetch request, if_addr (in, 32) fetch address, if_rdata (out, 32) fetched word, if_ack (out, 1) fetch completion pulse.
REQ-005 SHALL have ports me_req (in, 1) data request, me_we (in, 1) write when 1, me_addr (in, 32), me_wdata (in, 32), me_rdata (out, 32), me_ack (out, 1) data completion pulse.
REQ-006 SHALL have ports mem_valid (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32), mem_ready (in, 1) to the single shared memory.
REQ-007 SHALL have ports stall (out, 1) pipeline freeze and timeout_err (out, 1) sticky error flag.

Function
REQ-008 SHALL implement the FSM states IDLE, BUSY_IF, BUSY_ME, ACK.
- IDLE -> BUSY_IF or BUSY_ME on a granted request.
- BUSY_x -> ACK on mem_ready or on timeout.
- ACK -> IDLE unconditionally.
REQ-009 SHALL, in IDLE with any request, register the granted requester's address, we and wdata, and assert mem_valid from the next cycle. For fetches, mem_we=0 and mem_wdata=0.
REQ-010 SHALL hold mem_valid, mem_we, mem_addr and mem_wdata stable in BUSY_x until the cycle mem_ready=1 is sampled; mem_valid=0 in IDLE and ACK.
REQ-011 SHALL capture mem_rdata into the granted requester's rdata register on the mem_ready cycle. The rdata register holds its value until that requester's next completion. A write completion leaves me_rdata unchanged.
REQ-012 SHALL assert exactly one of if_ack/me_ack, for exactly one cycle, in ACK, and never in other states.
REQ-013 SHALL give latency as follows: request seen in IDLE at cycle N, mem_valid from N+1, mem_ready at M>=N+1, ack at M+1, IDLE at M+2. Minimum spacing between transactions is 3 cycles.
REQ-014 SHALL require requesters to hold req and request fields until ack. Req changes during BUSY_x are ignored. A req still high in the ACK cycle is ignored; it is re-arbitrated in IDLE.
REQ-015 SHALL drive stall = (if_req & ~if_ack) | (me_req & ~me_ack), combinationally.
REQ-016 SHALL count cycles in BUSY_x with mem_ready=0 in an 8-bit counter cleared on entry to BUSY_x. When the count reaches TIMEOUT_CYCLES (nonzero), the block SHALL:
- deassert mem_valid;
- load 32'hDEADBEEF into the requester's rdata (a write leaves me_rdata unchanged);
- go to ACK and set timeout_err.
REQ-017 SHALL treat mem_ready=1 and timeout in the same cycle as a normal completion, with no error.
REQ-018 SHALL ignore mem_ready while not in BUSY_x.

Reset
REQ-019 SHALL, while reset=0 and independently of clock:
- force state IDLE and clear the counter;
- set if_rdata, me_rdata to 32'h0;
- set if_ack, me_ack, mem_valid, mem_we, timeout_err to 0;
- set mem_addr, mem_wdata to 32'h0.
REQ-020 SHALL abandon any in-flight transaction on reset with no ack issued; the memory sees mem_valid drop immediately.
REQ-021 SHALL clear timeout_err only by reset.

Configuration
REQ-022 SHALL select round-robin arbitration when the macro MEM_ARB_ROUND_ROBIN_EN is defined:
- on simultaneous if_req and me_req in IDLE, grant the requester not granted last;
- the last-grant register resets to ME, so IF wins the first tie.
REQ-023 SHALL, without MEM_ARB_ROUND_ROBIN_EN, use fixed priority: me_req always wins ties, and no last-grant register exists.
REQ-024 SHALL behave identically in both configurations when only one requester is active.

Verification
REQ-025 SHALL cover a single fetch: if_req=1, if_addr=32'h00000040, mem_ready one cycle after mem_valid with mem_rdata=32'h20080005 -> mem_addr=32'h40, mem_we=0, if_ack pulses once with if_rdata=32'h20080005, stall drops with the ack.
REQ-026 SHALL cover a data write with 3 wait states: me_we=1, me_addr=32'h100, me_wdata=32'hCAFEF00D -> mem_valid held 4 cycles with fields stable, me_ack at M+1, me_rdata unchanged.
REQ-027 SHALL cover a tie: if_req and me_req rise together in three consecutive arbitrations.
- Without the macro: grant order ME, ME, ME.
- With the macro: grant order IF, ME, IF (each re-request after its ack).
REQ-028 SHALL cover timeout: TIMEOUT_CYCLES=4, if_req=1, mem_ready held 0 -> mem_valid high 4 cycles then low, if_ack with if_rdata=32'hDEADBEEF, timeout_err=1 and remaining 1 through later good transactions.
REQ-029 SHALL cover reset mid-transaction: reset=0 during BUSY_ME with mem_valid=1 -> mem_valid, me_ack and timeout_err become 0 without a clock edge, state IDLE after release, and the next if_req is served normally.
